// File: rtl/vga_pkg.sv
// Shared constants, helpers and state encodings for the line-buffer renderer.
package vga_pkg;

  localparam logic [11:0] COLOR_FG = 12'hFF0;
  localparam logic [11:0] COLOR_BG = 12'h208;

  function automatic bit bpp_legal(input int bpp);
    return (bpp == 1) || (bpp == 2) || (bpp == 4);
  endfunction

  function automatic int ppw(input int bpp);
    return 16 / bpp;
  endfunction

  typedef enum logic [1:0] {
    FETCH_IDLE,
    FETCH_READ,
    FETCH_CAPTURE
  } fetch_state_t;

  typedef enum logic {
    SWAP_IDLE,
    SWAP_PENDING
  } swap_state_t;

endpackage

// File: rtl/vga_palette.sv
// 16-entry 12-bit RGB palette: one synchronous write port, one combinational read port.
module vga_palette
  import vga_pkg::*;
#(
  parameter int BPP = 1
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        wr,
  input  logic [3:0]  wr_idx,
  input  logic [11:0] wr_data,
  input  logic [3:0]  rd_idx,
  output logic [11:0] rd_data
);

  localparam logic [3:0] IDX_MASK = 4'((1 << BPP) - 1);

  logic [11:0] regs [16];

  always_ff @(posedge clk) begin
    if (!nrst) begin
      for (int i = 0; i < 16; i++) begin
        if (i == 0)
          regs[i] <= COLOR_BG;
        else if (i == int'(IDX_MASK))
          regs[i] <= COLOR_FG;
        else
          regs[i] <= 12'h000;
      end
    end else if (wr) begin
      regs[wr_idx & IDX_MASK] <= wr_data;
    end
  end

  // Reads see the pre-write contents within the same clock.
  assign rd_data = regs[rd_idx & IDX_MASK];

endmodule

// File: rtl/vga_linebuf_renderer.sv
// Ping-pong line-buffer pixel generator: the writer fills the back bank while the
// front bank is scanned out through a 1/2/4-bpp palette to registered RGB.
module vga_linebuf_renderer
  import vga_pkg::*;
#(
  parameter int BPP       = 1,
  parameter int ADDR_W    = 8,
  parameter int H_VISIBLE = 800
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              pix_stb,
  input  logic              vis,
  input  logic              line_pre,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [15:0]       wr_data,
  input  logic              swap_req,
  output logic              swap_ack,
  output logic              disp_bank,
  input  logic              pal_wr,
  input  logic [3:0]        pal_idx,
  input  logic [11:0]       pal_data,
  output logic [3:0]        red,
  output logic [3:0]        green,
  output logic [3:0]        blue
);

  localparam int PPW   = ppw(BPP);
  localparam int IDX_W = $clog2(PPW);
  localparam int WORDS = H_VISIBLE / PPW;
  localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(WORDS - 1);

  if (!bpp_legal(BPP)) begin : g_bad_bpp
    $error("vga_linebuf_renderer: BPP must be 1, 2 or 4");
  end
  if ((WORDS > (2 ** ADDR_W)) || ((H_VISIBLE % PPW) != 0)) begin : g_bad_width
    $error("vga_linebuf_renderer: H_VISIBLE does not fit the line buffer");
  end

  logic [15:0]       mem [2 ** (ADDR_W + 1)];
  logic [15:0]       ram_q;
  logic [15:0]       next_word;
  logic [15:0]       shift;
  logic [15:0]       word_src;
  logic [ADDR_W-1:0] rd_addr;
  logic [ADDR_W-1:0] word_cnt;
  logic [IDX_W-1:0]  pix_idx;
  logic [BPP-1:0]    pix_p0;
  logic [11:0]       pal_rgb;
  logic              take_word;
  logic              fetch_start;
  fetch_state_t      fetch_state;
  swap_state_t       swap_state;

  always_ff @(posedge clk) begin
    if (!nrst) begin
      swap_state <= SWAP_IDLE;
      disp_bank  <= 1'b0;
      swap_ack   <= 1'b0;
    end else begin
      swap_ack <= 1'b0;
      if (line_pre && ((swap_state == SWAP_PENDING) || swap_req)) begin
        disp_bank  <= ~disp_bank;
        swap_ack   <= 1'b1;
        swap_state <= SWAP_IDLE;
      end else if (swap_req) begin
        swap_state <= SWAP_PENDING;
      end
    end
  end

  // Writes always use the bank that is back before this edge's swap.
  always_ff @(posedge clk) begin
    if (wr_en)
      mem[{~disp_bank, wr_addr}] <= wr_data;
    if (fetch_state == FETCH_READ)
      ram_q <= mem[{disp_bank, rd_addr}];
  end

  // A word landing in the same clock it is needed is forwarded straight from the RAM.
  assign word_src    = (fetch_state == FETCH_CAPTURE) ? ram_q : next_word;
  assign take_word   = pix_stb && vis && (pix_idx == '0);
  assign fetch_start = take_word && (word_cnt != LAST_WORD);
  assign pix_p0      = (pix_idx == '0) ? word_src[15 -: BPP] : shift[15 -: BPP];

  always_ff @(posedge clk) begin
    if (!nrst) begin
      fetch_state <= FETCH_IDLE;
      rd_addr     <= '0;
      word_cnt    <= '0;
      next_word   <= 16'h0000;
    end else if (line_pre) begin
      rd_addr     <= '0;
      word_cnt    <= '0;
      fetch_state <= FETCH_READ;
    end else begin
      if (take_word)
        word_cnt <= word_cnt + 1'b1;
      case (fetch_state)
        FETCH_READ: fetch_state <= FETCH_CAPTURE;
        FETCH_CAPTURE: begin
          next_word   <= ram_q;
          rd_addr     <= rd_addr + 1'b1;
          fetch_state <= fetch_start ? FETCH_READ : FETCH_IDLE;
        end
        default: begin
          if (fetch_start)
            fetch_state <= FETCH_READ;
        end
      endcase
    end
  end

  vga_palette #(
    .BPP(BPP)
  ) u_palette (
    .clk    (clk),
    .nrst   (nrst),
    .wr     (pal_wr),
    .wr_idx (pal_idx),
    .wr_data(pal_data),
    .rd_idx (4'(pix_p0)),
    .rd_data(pal_rgb)
  );

  // Stage p0 -> p1: pixel index resolved through the palette into the RGB registers.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      red     <= 4'h0;
      green   <= 4'h0;
      blue    <= 4'h0;
      shift   <= 16'h0000;
      pix_idx <= '0;
    end else if (pix_stb) begin
      if (vis) begin
        {red, green, blue} <= pal_rgb;
        shift   <= (pix_idx == '0) ? (word_src << BPP) : (shift << BPP);
        pix_idx <= pix_idx + 1'b1;
      end else begin
        {red, green, blue} <= 12'h000;
        pix_idx <= '0;
      end
    end
  end

endmodule

// File: tb/tb_vga_linebuf_renderer.sv
// Bench for vga_linebuf_renderer: three instances (BPP 1, 2, 4) share stimulus and are
// checked against a pixel-number based reference model of banks and palette.
module tb_vga_linebuf_renderer;

  localparam int HV = 800;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic        pix_stb = 1'b0;
  logic        vis = 1'b0;
  logic        line_pre = 1'b0;
  logic        wr_en = 1'b0;
  logic [7:0]  wr_addr = 8'h00;
  logic [15:0] wr_data = 16'h0000;
  logic        swap_req = 1'b0;
  logic        pal_wr = 1'b0;
  logic [3:0]  pal_idx = 4'h0;
  logic [11:0] pal_data = 12'h000;
  logic [2:0]  swap_ack;
  logic [2:0]  disp_bank;
  logic [3:0]  red [3];
  logic [3:0]  green [3];
  logic [3:0]  blue [3];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    vga_linebuf_renderer #(
      .BPP      (1 << g),
      .ADDR_W   (8),
      .H_VISIBLE(HV)
    ) u_dut (
      .clk      (clk),
      .nrst     (nrst),
      .pix_stb  (pix_stb),
      .vis      (vis),
      .line_pre (line_pre),
      .wr_en    (wr_en),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .swap_req (swap_req),
      .swap_ack (swap_ack[g]),
      .disp_bank(disp_bank[g]),
      .pal_wr   (pal_wr),
      .pal_idx  (pal_idx),
      .pal_data (pal_data),
      .red      (red[g]),
      .green    (green[g]),
      .blue     (blue[g])
    );
  end

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [15:0] m_mem [3][2][256];
  logic [11:0] m_pal [3][16];
  logic [11:0] last_rgb [3];
  logic        m_disp;
  logic        m_pending;

  function automatic logic [3:0] pmask(input int k);
    return 4'((1 << (1 << k)) - 1);
  endfunction

  function automatic logic [11:0] rgb(input int k);
    return {red[k], green[k], blue[k]};
  endfunction

  // Colour of the n-th visible pixel of the line for instance k.
  function automatic logic [11:0] exp_pix(input int k, input int n);
    int b, ppw_k, j, sh;
    logic [15:0] w, idx;
    b     = 1 << k;
    ppw_k = 16 / b;
    j     = n % ppw_k;
    w     = m_mem[k][m_disp][n / ppw_k];
    sh    = 16 - b * (j + 1);
    idx   = (w >> sh) & 16'((1 << b) - 1);
    return m_pal[k][idx[3:0]];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_disp    = 1'b0;
    m_pending = 1'b0;
    for (int k = 0; k < 3; k++) begin
      last_rgb[k] = 12'h000;
      for (int i = 0; i < 16; i++)
        m_pal[k][i] = (i == 0) ? 12'h208 : (4'(i) == pmask(k)) ? 12'hFF0 : 12'h000;
    end
  endtask

  task automatic drive_side(input bit do_wr, input bit do_pal);
    wr_en    = do_wr && ($urandom_range(0, 2) == 0);
    wr_addr  = 8'($urandom_range(0, 255));
    wr_data  = 16'($urandom);
    pal_wr   = do_pal && ($urandom_range(0, 3) == 0);
    pal_idx  = 4'($urandom_range(0, 15));
    pal_data = 12'($urandom);
  endtask

  task automatic commit_side(input logic bank);
    for (int k = 0; k < 3; k++) begin
      if (wr_en)
        m_mem[k][bank][wr_addr] = wr_data;
      if (pal_wr)
        m_pal[k][pal_idx & pmask(k)] = pal_data;
    end
    wr_en  = 1'b0;
    pal_wr = 1'b0;
  endtask

  task automatic fill_back(input int kind);
    for (int a = 0; a < 256; a++) begin
      wr_en   = 1'b1;
      wr_addr = 8'(a);
      case (kind)
        0:       wr_data = 16'hAAAA;
        1:       wr_data = 16'h1B1B;
        2:       wr_data = 16'hFFFF;
        default: wr_data = 16'(a * 16'h1357 + 1);
      endcase
      tick();
      commit_side(~m_disp);
    end
  endtask

  task automatic pal_write(input logic [3:0] idx, input logic [11:0] data);
    pal_wr   = 1'b1;
    pal_idx  = idx;
    pal_data = data;
    tick();
    commit_side(~m_disp);
  endtask

  task automatic req_swap(input string name);
    swap_req = 1'b1;
    tick();
    swap_req  = 1'b0;
    m_pending = 1'b1;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (swap_ack[k] !== 1'b0) begin
        errors++;
        $display("FAIL %s dut%0d swap_ack=%b expected 0 without line_pre", name, k, swap_ack[k]);
      end
    end
  endtask

  // One scan line: line_pre on a blank strobe, then npix visible strobes with random gaps.
  task automatic run_line(input string name, input int npix, input int gmin, input int gmax,
                          input bit swap_pre, input bit do_wr, input bit do_pal);
    logic        exp_swap, old_back;
    logic [11:0] expv [3];
    int          gap;
    drive_side(do_wr, 1'b0);
    pix_stb  = 1'b1;
    vis      = 1'b0;
    line_pre = 1'b1;
    swap_req = swap_pre;
    old_back = ~m_disp;
    exp_swap = m_pending | swap_pre;
    tick();
    pix_stb  = 1'b0;
    line_pre = 1'b0;
    swap_req = 1'b0;
    commit_side(old_back);
    if (exp_swap) begin
      m_disp    = ~m_disp;
      m_pending = 1'b0;
    end
    for (int k = 0; k < 3; k++) begin
      last_rgb[k] = 12'h000;
      checks += 3;
      if (swap_ack[k] !== exp_swap) begin
        errors++;
        $display("FAIL %s dut%0d swap_ack=%b expected %b", name, k, swap_ack[k], exp_swap);
      end
      if (disp_bank[k] !== m_disp) begin
        errors++;
        $display("FAIL %s dut%0d disp_bank=%b expected %b", name, k, disp_bank[k], m_disp);
      end
      if (rgb(k) !== 12'h000) begin
        errors++;
        $display("FAIL %s dut%0d blank rgb=%h expected 000", name, k, rgb(k));
      end
    end
    for (int n = 0; n < npix; n++) begin
      gap = $urandom_range(gmin, gmax);
      for (int g = 1; g < gap; g++) begin
        drive_side(do_wr, do_pal);
        tick();
        commit_side(~m_disp);
        for (int k = 0; k < 3; k++) begin
          checks += 2;
          if (swap_ack[k] !== 1'b0) begin
            errors++;
            $display("FAIL %s dut%0d px%0d swap_ack=%b expected 0", name, k, n, swap_ack[k]);
          end
          if (rgb(k) !== last_rgb[k]) begin
            errors++;
            $display("FAIL %s dut%0d hold before px%0d rgb=%h expected %h", name, k, n, rgb(k), last_rgb[k]);
          end
        end
      end
      drive_side(do_wr, do_pal);
      pix_stb = 1'b1;
      vis     = 1'b1;
      for (int k = 0; k < 3; k++)
        expv[k] = exp_pix(k, n);
      tick();
      pix_stb = 1'b0;
      vis     = 1'b0;
      commit_side(~m_disp);
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (rgb(k) !== expv[k]) begin
          errors++;
          $display("FAIL %s dut%0d px%0d rgb=%h expected %h", name, k, n, rgb(k), expv[k]);
        end
        last_rgb[k] = expv[k];
      end
    end
    if (npix == HV) begin
      for (int b = 0; b < 4; b++) begin
        tick();
        pix_stb = 1'b1;
        vis     = 1'b0;
        tick();
        pix_stb = 1'b0;
        for (int k = 0; k < 3; k++) begin
          checks++;
          if (rgb(k) !== 12'h000) begin
            errors++;
            $display("FAIL %s dut%0d hblank rgb=%h expected 000", name, k, rgb(k));
          end
          last_rgb[k] = 12'h000;
        end
      end
      tick();
    end
  endtask

  task automatic test_reset();
    nrst = 1'b0;
    tick();
    tick();
    for (int k = 0; k < 3; k++) begin
      checks += 3;
      if (rgb(k) !== 12'h000) begin
        errors++;
        $display("FAIL reset dut%0d rgb=%h expected 000", k, rgb(k));
      end
      if (swap_ack[k] !== 1'b0) begin
        errors++;
        $display("FAIL reset dut%0d swap_ack=%b expected 0", k, swap_ack[k]);
      end
      if (disp_bank[k] !== 1'b0) begin
        errors++;
        $display("FAIL reset dut%0d disp_bank=%b expected 0", k, disp_bank[k]);
      end
    end
    model_reset();
    nrst = 1'b1;
    tick();
  endtask

  task automatic test_bpp1_default();
    fill_back(0);
    req_swap("bpp1_req");
    run_line("bpp1_default", HV, 2, 4, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_bpp2_palette();
    pal_write(4'd1, 12'h0F0);
    pal_write(4'd2, 12'h00F);
    fill_back(1);
    req_swap("bpp2_req");
    run_line("bpp2_palette", HV, 2, 4, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_write_during_scan();
    fill_back(2);
    req_swap("wscan_req");
    run_line("ffff_front_writes", HV, 2, 4, 1'b0, 1'b1, 1'b0);
    run_line("swap_with_pre", HV, 2, 4, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic test_double_swap();
    req_swap("dbl_req1");
    tick();
    req_swap("dbl_req2");
    run_line("double_swap", HV, 2, 4, 1'b0, 1'b0, 1'b0);
    run_line("no_swap", HV, 2, 4, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_palette_same_clk();
    run_line("pal_rand", HV, 2, 3, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_reset_midline();
    run_line("pre_reset", 100, 2, 3, 1'b0, 1'b0, 1'b0);
    req_swap("pre_reset_req");
    pix_stb = 1'b1;
    vis     = 1'b1;
    nrst    = 1'b0;
    tick();
    pix_stb = 1'b0;
    vis     = 1'b0;
    nrst    = 1'b1;
    for (int k = 0; k < 3; k++) begin
      checks += 3;
      if (rgb(k) !== 12'h000) begin
        errors++;
        $display("FAIL midline_reset dut%0d rgb=%h expected 000", k, rgb(k));
      end
      if (disp_bank[k] !== 1'b0) begin
        errors++;
        $display("FAIL midline_reset dut%0d disp_bank=%b expected 0", k, disp_bank[k]);
      end
      if (swap_ack[k] !== 1'b0) begin
        errors++;
        $display("FAIL midline_reset dut%0d swap_ack=%b expected 0", k, swap_ack[k]);
      end
    end
    model_reset();
    repeat (3) tick();
    run_line("after_reset", HV, 2, 3, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_min_spacing_bpp4();
    for (int i = 0; i < 16; i++)
      pal_write(4'(i), 12'($urandom));
    fill_back(3);
    req_swap("minsp_req");
    run_line("min_spacing", HV, 2, 2, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_bpp1_default();
    test_bpp2_palette();
    test_write_during_scan();
    test_double_swap();
    test_palette_same_clk();
    test_reset_midline();
    test_min_spacing_bpp4();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
